// File: rtl/control_sequencer_pkg.sv
// Shared constants for the 4-bit datapath control unit: opcodes, step numbers
// and the control-word bit layout, plus the per-opcode final-step lookup.
package control_sequencer_pkg;

    localparam int STEP_W   = 3;
    localparam int OPCODE_W = 4;
    localparam int CW_W     = 15;

    localparam logic [OPCODE_W-1:0] OP_NOP = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_STA = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_LDI = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_JC  = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

    localparam logic [STEP_W-1:0] T0 = 3'd0;
    localparam logic [STEP_W-1:0] T1 = 3'd1;
    localparam logic [STEP_W-1:0] T2 = 3'd2;
    localparam logic [STEP_W-1:0] T3 = 3'd3;
    localparam logic [STEP_W-1:0] T4 = 3'd4;
    localparam logic [STEP_W-1:0] T5 = 3'd5;

    typedef enum logic [3:0] {
        CW_ENABLE_PC, CW_INC_PC, CW_LOAD_PC, CW_LATCH_MAR, CW_ENABLE_RAM,
        CW_WRITE_RAM, CW_LATCH_IR, CW_ENABLE_IR, CW_LATCH_ACC, CW_ENABLE_ACC,
        CW_LATCH_B, CW_ENABLE_ALU, CW_ALU_SUB, CW_LATCH_FLAGS, CW_LATCH_OUT
    } cw_idx_e;

    // Undefined opcodes fall through to the NOP length.
    function automatic logic [STEP_W-1:0] last_step(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_LDA, OP_STA:                                  last_step = T4;
            OP_ADD, OP_SUB:                                  last_step = T5;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:    last_step = T3;
            default:                                         last_step = T2;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Opcode/flag inputs and control-word outputs between the sequencer and the datapath.
interface control_sequencer_if;
    import control_sequencer_pkg::*;

    logic [OPCODE_W-1:0] ToInstr;
    logic                CarryFlag;
    logic                ZeroFlag;
    logic [STEP_W-1:0]   Step;
    logic                Halted;
    logic                ClearInstrReg;
    logic EnablePC, IncPC, LoadPC;
    logic LatchMAR, EnableRAM, WriteRAM;
    logic LatchInstrReg, EnableInstrReg;
    logic LatchAcc, EnableAcc, LatchB, EnableAlu, AluSub, LatchFlags, LatchOut;

    modport master (
        input  ToInstr, CarryFlag, ZeroFlag,
        output Step, Halted, ClearInstrReg,
        output EnablePC, IncPC, LoadPC, LatchMAR, EnableRAM, WriteRAM,
        output LatchInstrReg, EnableInstrReg, LatchAcc, EnableAcc, LatchB,
        output EnableAlu, AluSub, LatchFlags, LatchOut
    );

    modport slave (
        output ToInstr, CarryFlag, ZeroFlag,
        input  Step, Halted, ClearInstrReg,
        input  EnablePC, IncPC, LoadPC, LatchMAR, EnableRAM, WriteRAM,
        input  LatchInstrReg, EnableInstrReg, LatchAcc, EnableAcc, LatchB,
        input  EnableAlu, AluSub, LatchFlags, LatchOut
    );
endinterface

// File: rtl/control_sequencer_step_counter.sv
// Instruction step counter T0..T5: async clear, synchronous return to T0, hold.
// Hold has priority over return-to-zero; counting past T5 wraps to T0.
module control_sequencer_step_counter
    import control_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              hold_i,
    output logic [STEP_W-1:0] step_o
);

    logic [STEP_W-1:0] step_q, step_d;

    always_comb begin
        step_d = step_q;
        if (!hold_i) begin
            step_d = (clr_i || step_q >= T5) ? T0 : step_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) step_q <= T0;
        else     step_q <= step_d;
    end

    assign step_o = step_q;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: decodes step, opcode and flags into the control word.
// All control outputs are combinational; only the step counter and halt flag are state.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic                 MainClock,
    input  logic                 ClearControl,
    control_sequencer_if.master  bus
);

    logic [STEP_W-1:0] step;
    logic              halted_q, halted_d;
    logic              hlt_now;
    logic [CW_W-1:0]   cw;

    assign hlt_now  = !halted_q && (step == T3) && (bus.ToInstr == OP_HLT);
    assign halted_d = halted_q | hlt_now;

    control_sequencer_step_counter u_step (
        .clk    (MainClock),
        .rst    (ClearControl),
        .clr_i  (step == last_step(bus.ToInstr)),
        .hold_i (halted_q | hlt_now),
        .step_o (step)
    );

    always_ff @(posedge MainClock or posedge ClearControl) begin
        if (ClearControl) halted_q <= 1'b0;
        else              halted_q <= halted_d;
    end

    always_comb begin
        cw = '0;
        case (step)
            T0: begin cw[CW_ENABLE_PC]  = 1'b1; cw[CW_LATCH_MAR] = 1'b1; end
            T1: begin cw[CW_ENABLE_RAM] = 1'b1; cw[CW_LATCH_IR]  = 1'b1; end
            T2: cw[CW_INC_PC] = 1'b1;
            T3: case (bus.ToInstr)
                OP_LDA, OP_ADD, OP_SUB, OP_STA:
                    begin cw[CW_ENABLE_IR] = 1'b1; cw[CW_LATCH_MAR] = 1'b1; end
                OP_LDI: begin cw[CW_ENABLE_IR] = 1'b1; cw[CW_LATCH_ACC] = 1'b1; end
                OP_JMP: begin cw[CW_ENABLE_IR] = 1'b1; cw[CW_LOAD_PC]   = 1'b1; end
                OP_JC:  begin cw[CW_ENABLE_IR] = bus.CarryFlag; cw[CW_LOAD_PC] = bus.CarryFlag; end
                OP_JZ:  begin cw[CW_ENABLE_IR] = bus.ZeroFlag;  cw[CW_LOAD_PC] = bus.ZeroFlag;  end
                OP_OUT: begin cw[CW_ENABLE_ACC] = 1'b1; cw[CW_LATCH_OUT] = 1'b1; end
                default: cw = '0;
            endcase
            T4: case (bus.ToInstr)
                OP_LDA:         begin cw[CW_ENABLE_RAM] = 1'b1; cw[CW_LATCH_ACC] = 1'b1; end
                OP_ADD, OP_SUB: begin cw[CW_ENABLE_RAM] = 1'b1; cw[CW_LATCH_B]   = 1'b1; end
                OP_STA:         begin cw[CW_ENABLE_ACC] = 1'b1; cw[CW_WRITE_RAM] = 1'b1; end
                default:        cw = '0;
            endcase
            T5: if (bus.ToInstr == OP_ADD || bus.ToInstr == OP_SUB) begin
                cw[CW_ENABLE_ALU]  = 1'b1;
                cw[CW_LATCH_ACC]   = 1'b1;
                cw[CW_LATCH_FLAGS] = 1'b1;
                cw[CW_ALU_SUB]     = (bus.ToInstr == OP_SUB);
            end
            default: cw = '0;
        endcase
        if (halted_q) cw = '0;
    end

    assign bus.Step           = step;
    assign bus.Halted         = halted_q;
    assign bus.ClearInstrReg  = ClearControl;
    assign bus.EnablePC       = cw[CW_ENABLE_PC];
    assign bus.IncPC          = cw[CW_INC_PC];
    assign bus.LoadPC         = cw[CW_LOAD_PC];
    assign bus.LatchMAR       = cw[CW_LATCH_MAR];
    assign bus.EnableRAM      = cw[CW_ENABLE_RAM];
    assign bus.WriteRAM       = cw[CW_WRITE_RAM];
    assign bus.LatchInstrReg  = cw[CW_LATCH_IR];
    assign bus.EnableInstrReg = cw[CW_ENABLE_IR];
    assign bus.LatchAcc       = cw[CW_LATCH_ACC];
    assign bus.EnableAcc      = cw[CW_ENABLE_ACC];
    assign bus.LatchB         = cw[CW_LATCH_B];
    assign bus.EnableAlu      = cw[CW_ENABLE_ALU];
    assign bus.AluSub         = cw[CW_ALU_SUB];
    assign bus.LatchFlags     = cw[CW_LATCH_FLAGS];
    assign bus.LatchOut       = cw[CW_LATCH_OUT];

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microprogram-free control unit for the 4-bit datapath. It sits directly downstream of the instruction register and consumes its ToInstr[3:0] opcode outputs. A step counter (T0–T5) is decoded together with that opcode and the ALU flags into the per-cycle control word. The control word drives the PC, MAR, RAM, instruction register, accumulator, B register, ALU and output register.

## Interface
- STEP_W, 3, width of the step counter (steps T0..T5 used)
- OPCODE_W, 4, width of the opcode from the instruction register
- MainClock  in  1  single system clock; all state changes on its rising edge
- ClearControl  in  1  asynchronous, active-high reset
- ToInstr  in  4  opcode from instruction register (valid from T2 onward)
- CarryFlag, ZeroFlag  in  1 each  registered ALU flags
- Step  out  3  current step, for debug/bench
- Halted  out  1  sticky halt indicator
- ClearInstrReg  out  1  equals ClearControl (combinational pass-through)
- EnablePC, IncPC, LoadPC  out  1 each  program counter controls
- LatchMAR, EnableRAM, WriteRAM  out  1 each  memory controls
- LatchInstrReg, EnableInstrReg  out  1 each  instruction register controls (EnableInstrReg drives operand nibble onto bus)
- LatchAcc, EnableAcc, LatchB, EnableAlu, AluSub, LatchFlags, LatchOut  out  1 each  datapath controls

## Operation
- Step register counts T0→T1→…; the last step of each instruction returns it to T0 on the next edge. It never exceeds T5.
- Fetch, common to all opcodes:
  - T0: EnablePC, LatchMAR.
  - T1: EnableRAM, LatchInstrReg.
  - T2: IncPC.
- Execute, by opcode; the last step listed is final:
  - 0000 NOP: ends at T2.
  - 0001 LDA: T3 EnableInstrReg, LatchMAR; T4 EnableRAM, LatchAcc.
  - 0010 ADD: T3 EnableInstrReg, LatchMAR; T4 EnableRAM, LatchB; T5 EnableAlu, LatchAcc, LatchFlags.
  - 0011 SUB: as ADD, with AluSub also high at T5.
  - 0100 STA: T3 EnableInstrReg, LatchMAR; T4 EnableAcc, WriteRAM.
  - 0101 LDI: T3 EnableInstrReg, LatchAcc.
  - 0110 JMP: T3 EnableInstrReg, LoadPC.
  - 0111 JC: T3 EnableInstrReg, LoadPC only if CarryFlag=1; otherwise T3 has an all-zero word. Either way T3 is final.
  - 1000 JZ: as JC, using ZeroFlag.
  - 1110 OUT: T3 EnableAcc, LatchOut.
  - 1111 HLT: at T3, Halted is set on the next edge.
  - 1001–1101 are undefined and behave as NOP, ending at T2.
- Halted=1 freezes Step and forces every control output except ClearInstrReg to 0. Only ClearControl leaves the halt.
- Invariant: at most one of EnablePC, EnableRAM, EnableInstrReg, EnableAcc, EnableAlu is high in any step (single bus driver).
- Control outputs are combinational decodes of Step, ToInstr, flags and Halted; no output is registered.

## Timing
- Reset (ClearControl=1, async): Step=0, Halted=0 immediately, without waiting for a clock edge.
  - Outputs then show the T0 word: EnablePC=1, LatchMAR=1, all other controls 0, ClearInstrReg=1.
- Reset takes effect mid-instruction at any step, with no completion of the current instruction.
- First edge after ClearControl falls moves to T1.
- Latency: the opcode is latched at the end of T1 and decoded from T2.
- Instruction lengths:
  - NOP/undefined: 3 cycles.
  - LDI, JMP, JC, JZ, OUT: 4 cycles.
  - LDA, STA: 5 cycles.
  - ADD, SUB: 6 cycles.
- Jumps sample flags combinationally during T3. A flag change at the T3→T0 edge does not alter the taken decision.
- HLT: Halted rises on the edge ending T3. Step stays at 3.

## Structure
- Shared package holds:
  - the opcode constants OP_NOP…OP_HLT;
  - step constants T0..T5;
  - a control-word bit-index enumeration reused by datapath blocks.
- One natural sub-module: step_counter (3-bit, async clear, synchronous return-to-zero input, hold input). The decode stays in control_sequencer.

## Test plan
- Reset mid-ADD at T4, asserted between edges: Step=0 and Halted=0 immediately; EnablePC=1, LatchMAR=1; ClearInstrReg=1 while ClearControl is high.
- LDA 0001 from reset: Step runs 0,1,2,3,4,0. The control words per step match the Operation list, and the next fetch starts at cycle 6.
- SUB 0011: the 6-cycle sequence has AluSub=1 and LatchFlags=1 only at T5. Bench checks the single-driver invariant every cycle.
- JC with CarryFlag=0, then CarryFlag=1: LoadPC=0, then LoadPC=1 at T3. Both return to T0 after 4 cycles.
- Opcode 1011: treated as NOP, Step returns to 0 after T2, no execute controls are asserted.
- HLT 1111: Halted=1 after T3. Step is held at 3 and all controls are 0 for 20 further cycles; ClearControl then restarts at T0.
